int_rti_sequencer: RTL
======================

Name: int_rti_sequencer

Overview:
- Multi-cycle controller that takes over the EX/MEM datapath to service a hardware interrupt and to execute RTI.
- On interrupt: drains the pipeline, pushes the return PC (two words) and the Z/N/C flags onto the stack, fetches the 32-bit handler address from the vector location, then redirects the PC.
- On RTI: pops the flags and PC in reverse order, then restores them.
- Sits beside the EX stage. It drives the CCR flag-restore path, the INT-flag set/clear signals and the PC-load path, and issues stack micro-ops to the memory stage.

Parameters:
- VEC_ADDR, 32'd0, word address of handler vector high word; low word is at VEC_ADDR+1.
- DRAIN_CYCLES, 3, cycles to let in-flight instructions retire before the takeover; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- int_pin  input  1  external interrupt request; rising edge is significant.
- int_en  input  1  current CCR INT flag; interrupts are accepted only when 1.
- is_rti  input  1  decoded RTI present in EX this cycle.
- next_pc  input  32  PC of the instruction to resume at.
- flags_in  input  3  live CCR flags {Z,N,C}.
- mem_ready  input  1  memory accepted/completed current micro-op.
- mem_rdata  input  16  read data from memory.
- stall  output  1  freeze fetch/decode.
- flush  output  1  one-cycle bubble insertion into ID/EX.
- mem_req  output  1  micro-op valid.
- mem_we  output  1  1 write, 0 read.
- sp_op  output  2  00 none, 01 push (pre-decrement SP), 10 pop (post-increment SP).
- mem_addr  output  32  absolute address when sp_op=00.
- mem_wdata  output  16  write data.
- pc_load  output  1  load PC from pc_load_val.
- pc_load_val  output  32  new PC.
- flags_load  output  1  write flags_val into CCR.
- flags_val  output  3  {Z,N,C} to restore.
- clr_int  output  1  one-cycle clear of the INT flag.
- set_int  output  1  one-cycle set of the INT flag.
- int_ack  output  1  one-cycle acknowledge when the handler PC is loaded.
- busy  output  1  FSM not in IDLE.

Behaviour:

Reset:
- All outputs are 0.
- State is IDLE, the pending flag is cleared, and the drain counter is 0.
- Reset mid-sequence aborts immediately; no partial flag or PC load is issued.

Interrupt capture:
- A registered edge detector on int_pin sets pending on a 0->1 transition.
- Pending is cleared only on entry to PUSH_PC_HI.

IDLE:
- If is_rti=1, go to DRAIN with mode=RTI. RTI wins over a simultaneous interrupt; pending is kept.
- Otherwise, if pending=1 and int_en=1, go to DRAIN with mode=INT and capture next_pc into ret_pc.

DRAIN:
- stall=1. The counter loads DRAIN_CYCLES-1 on entry and decrements each cycle.
- At 0: assert flush for that cycle and capture flags_in into saved_flags (INT mode only).
- Next state is PUSH_PC_HI (INT) or POP_FLAGS (RTI).
- clr_int is pulsed in the first DRAIN cycle of INT mode.

Memory micro-op states:
- mem_req=1, with addr, data, mem_we and sp_op held stable until a clock edge samples mem_ready=1, then advance.
- mem_ready is ignored when mem_req=0.
- INT sequence:
  - PUSH_PC_HI: wdata=ret_pc[31:16].
  - PUSH_PC_LO: wdata=ret_pc[15:0].
  - PUSH_FLAGS: wdata={13'b0, saved_flags}.
  - VEC_HI: read at VEC_ADDR; latch rdata into tgt[31:16].
  - VEC_LO: read at VEC_ADDR+1; latch rdata into tgt[15:0].
  - Then RESUME.
- RTI sequence:
  - POP_FLAGS: flags_load=1 in the accepting cycle, flags_val=mem_rdata[2:0].
  - POP_PC_LO: latch rdata into tgt[15:0].
  - POP_PC_HI: latch rdata into tgt[31:16].
  - Then RESUME.

RESUME:
- One cycle: pc_load=1, pc_load_val=tgt, stall=1.
- INT mode: int_ack=1. RTI mode: set_int=1.
- Next state is IDLE. At least one IDLE cycle always separates back-to-back sequences.

Outputs by state:
- stall=busy in all non-IDLE states.
- Micro-op outputs are 0 outside the memory states.

Edge cases:
- An int_pin edge arriving while busy is latched and serviced after return to IDLE, provided int_en=1.
- is_rti while busy is ignored; decode is stalled.

Decomposition:
- Shared defines file holds:
  - state encodings: IDLE, DRAIN, PUSH_PC_HI, PUSH_PC_LO, PUSH_FLAGS, VEC_HI, VEC_LO, POP_FLAGS, POP_PC_LO, POP_PC_HI, RESUME;
  - sp_op codes;
  - the flags word layout.
- One sub-module: int_edge_latch (edge detector plus pending register, async active-low reset, clear input).

Test Plan:
1. Interrupt entry: int_en=1, next_pc=32'h0001_0020, flags_in=3'b101; pulse int_pin; memory answers VEC_ADDR->16'h0000 and VEC_ADDR+1->16'h0400.
   - Required: 3 stall cycles, flush on the 3rd.
   - Required: pushes 16'h0001, 16'h0020, 16'h0005.
   - Required: pc_load_val=32'h0000_0400 with int_ack and clr_int each pulsed once.
2. RTI: memory pops 16'h0003, 16'h0020, 16'h0001.
   - Required: flags_load with flags_val=3'b011, then pc_load_val=32'h0001_0020, set_int=1 for one cycle.
3. mem_ready held low 5 cycles in PUSH_PC_LO.
   - Required: mem_req, mem_wdata=16'h0020 and sp_op=01 stay stable; no advance until mem_ready=1.
4. int_pin edge with int_en=0.
   - Required: no sequence starts. Raising int_en later starts DRAIN the following cycle.
5. is_rti and a pending interrupt in the same IDLE cycle.
   - Required: RTI runs first. The interrupt is serviced after one IDLE cycle, with the restored int_en=1.
6. Assert reset low during VEC_LO.
   - Required: all outputs 0 asynchronously, busy=0, pending=0, and no pc_load after reset is released.

Source files
------------

// File: rtl/int_rti_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : int_rti_sequencer_pkg
//  Purpose  : Shared definitions for the interrupt / RTI sequencer: FSM state
//             encodings, sequence mode, stack micro-op codes and the CCR
//             flags word layout.
//  Revision : 1.0 - initial release
// ============================================================================
package int_rti_sequencer_pkg;

    // FSM state encodings
    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_DRAIN      = 4'd1,
        ST_PUSH_PC_HI = 4'd2,
        ST_PUSH_PC_LO = 4'd3,
        ST_PUSH_FLAGS = 4'd4,
        ST_VEC_HI     = 4'd5,
        ST_VEC_LO     = 4'd6,
        ST_POP_FLAGS  = 4'd7,
        ST_POP_PC_LO  = 4'd8,
        ST_POP_PC_HI  = 4'd9,
        ST_RESUME     = 4'd10
    } state_t;

    // Which sequence the FSM is running
    typedef enum logic {
        MODE_INT = 1'b0,
        MODE_RTI = 1'b1
    } mode_t;

    // Stack micro-op codes issued to the memory stage
    localparam logic [1:0] SP_NONE = 2'b00;   // absolute address access
    localparam logic [1:0] SP_PUSH = 2'b01;   // pre-decrement SP, then write
    localparam logic [1:0] SP_POP  = 2'b10;   // read, then post-increment SP

    // Flags word layout: bit 2 = Z, bit 1 = N, bit 0 = C; upper bits zero.
    localparam int FLAGS_W = 3;
    typedef logic [FLAGS_W-1:0] flags_t;

    function automatic logic [15:0] flags_to_word(input flags_t f);
        return {{(16-FLAGS_W){1'b0}}, f};
    endfunction

    function automatic logic is_push_state(input state_t s);
        return (s == ST_PUSH_PC_HI) || (s == ST_PUSH_PC_LO) || (s == ST_PUSH_FLAGS);
    endfunction

    function automatic logic is_pop_state(input state_t s);
        return (s == ST_POP_FLAGS) || (s == ST_POP_PC_LO) || (s == ST_POP_PC_HI);
    endfunction

    function automatic logic is_mem_state(input state_t s);
        return is_push_state(s) || is_pop_state(s) || (s == ST_VEC_HI) || (s == ST_VEC_LO);
    endfunction

endpackage
`default_nettype wire

// File: rtl/int_rti_sequencer_edge_latch.sv
`default_nettype none
// ============================================================================
//  Module   : int_edge_latch
//  Purpose  : Registered rising-edge detector on the interrupt pin plus a
//             sticky pending flag.
//  Ports    : clk     - system clock
//             reset   - asynchronous active-low reset
//             int_pin - raw interrupt request
//             clear   - drop the pending flag (sequence has committed)
//             pending - an edge has been seen and not yet serviced
//  Revision : 1.0 - initial release
// ============================================================================
module int_edge_latch (
    input  logic clk,
    input  logic reset,
    input  logic int_pin,
    input  logic clear,
    output logic pending
);

    logic r_pin_d;
    logic r_pending;
    logic w_rise;

    assign w_rise = int_pin & ~r_pin_d;

    // A new edge coinciding with the clear must not be lost, so set wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pin_d   <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_pin_d <= int_pin;
            if (w_rise) begin
                r_pending <= 1'b1;
            end else if (clear) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign pending = r_pending;

endmodule
`default_nettype wire

// File: rtl/int_rti_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : int_rti_sequencer
//  Purpose  : Multi-cycle controller that takes over the EX/MEM datapath to
//             enter an interrupt handler (push PC/flags, fetch vector) or to
//             execute RTI (pop flags/PC), then redirects the PC.
//  Ports    : clk, reset (async active-low)
//             int_pin, int_en, is_rti, next_pc, flags_in   - core status in
//             mem_ready, mem_rdata                         - memory response
//             stall, flush, busy                           - pipeline control
//             mem_req, mem_we, sp_op, mem_addr, mem_wdata  - stack micro-op
//             pc_load, pc_load_val                         - PC redirect
//             flags_load, flags_val, clr_int, set_int      - CCR update
//             int_ack                                      - handler entered
//  Revision : 1.0 - initial release
// ============================================================================
module int_rti_sequencer
    import int_rti_sequencer_pkg::*;
#(
    parameter logic [31:0] VEC_ADDR     = 32'd0,
    parameter int          DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        int_pin,
    input  logic        int_en,
    input  logic        is_rti,
    input  logic [31:0] next_pc,
    input  logic [2:0]  flags_in,
    input  logic        mem_ready,
    input  logic [15:0] mem_rdata,
    output logic        stall,
    output logic        flush,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  sp_op,
    output logic [31:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        pc_load,
    output logic [31:0] pc_load_val,
    output logic        flags_load,
    output logic [2:0]  flags_val,
    output logic        clr_int,
    output logic        set_int,
    output logic        int_ack,
    output logic        busy
);

    localparam logic [3:0] C_DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

    // Sequence state
    state_t      r_state;
    mode_t       r_mode;
    logic [3:0]  r_cnt;
    logic [31:0] r_ret_pc;
    flags_t      r_saved_flags;
    logic [31:0] r_tgt;

    // Registered outputs
    logic        r_stall, r_flush, r_busy;
    logic        r_mem_req, r_mem_we;
    logic [1:0]  r_sp_op;
    logic [31:0] r_mem_addr;
    logic [15:0] r_mem_wdata;
    logic        r_pc_load, r_clr_int, r_set_int, r_int_ack;
    logic [31:0] r_pc_load_val;

    // Next-cycle values
    state_t      w_next_state;
    mode_t       w_next_mode;
    logic [3:0]  w_next_cnt;
    logic [31:0] w_next_tgt;
    logic        w_accept;
    logic        w_start;
    logic        w_pending;
    logic        w_clear_pending;
    logic [1:0]  w_sp_op;
    logic [31:0] w_mem_addr;
    logic [15:0] w_mem_wdata;

    // The pending flag drops when the INT sequence commits to its first push.
    assign w_clear_pending = (r_state == ST_DRAIN) && (r_cnt == 4'd0) && (r_mode == MODE_INT);

    int_edge_latch u_edge_latch (
        .clk     (clk),
        .reset   (reset),
        .int_pin (int_pin),
        .clear   (w_clear_pending),
        .pending (w_pending)
    );

    assign w_accept = is_mem_state(r_state) && mem_ready;
    assign w_start  = (r_state == ST_IDLE) && (w_next_state == ST_DRAIN);

    always_comb begin
        w_next_state = r_state;
        w_next_mode  = r_mode;
        w_next_cnt   = r_cnt;
        w_next_tgt   = r_tgt;
        case (r_state)
            ST_IDLE: begin
                // RTI has priority; a pending interrupt simply waits.
                if (is_rti) begin
                    w_next_state = ST_DRAIN;
                    w_next_mode  = MODE_RTI;
                    w_next_cnt   = C_DRAIN_LAST;
                end else if (w_pending && int_en) begin
                    w_next_state = ST_DRAIN;
                    w_next_mode  = MODE_INT;
                    w_next_cnt   = C_DRAIN_LAST;
                end
            end
            ST_DRAIN: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = (r_mode == MODE_INT) ? ST_PUSH_PC_HI : ST_POP_FLAGS;
                end else begin
                    w_next_cnt = r_cnt - 4'd1;
                end
            end
            ST_PUSH_PC_HI: if (w_accept) w_next_state = ST_PUSH_PC_LO;
            ST_PUSH_PC_LO: if (w_accept) w_next_state = ST_PUSH_FLAGS;
            ST_PUSH_FLAGS: if (w_accept) w_next_state = ST_VEC_HI;
            ST_VEC_HI: begin
                if (w_accept) begin
                    w_next_state       = ST_VEC_LO;
                    w_next_tgt[31:16]  = mem_rdata;
                end
            end
            ST_VEC_LO: begin
                if (w_accept) begin
                    w_next_state       = ST_RESUME;
                    w_next_tgt[15:0]   = mem_rdata;
                end
            end
            ST_POP_FLAGS:  if (w_accept) w_next_state = ST_POP_PC_LO;
            ST_POP_PC_LO: begin
                if (w_accept) begin
                    w_next_state       = ST_POP_PC_HI;
                    w_next_tgt[15:0]   = mem_rdata;
                end
            end
            ST_POP_PC_HI: begin
                if (w_accept) begin
                    w_next_state       = ST_RESUME;
                    w_next_tgt[31:16]  = mem_rdata;
                end
            end
            ST_RESUME: w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Micro-op fields for the state being entered; held constant while the
    // state waits for mem_ready because they depend only on that state.
    always_comb begin
        w_sp_op     = SP_NONE;
        w_mem_addr  = 32'd0;
        w_mem_wdata = 16'd0;
        if (is_push_state(w_next_state)) begin
            w_sp_op = SP_PUSH;
        end else if (is_pop_state(w_next_state)) begin
            w_sp_op = SP_POP;
        end
        case (w_next_state)
            ST_PUSH_PC_HI: w_mem_wdata = r_ret_pc[31:16];
            ST_PUSH_PC_LO: w_mem_wdata = r_ret_pc[15:0];
            ST_PUSH_FLAGS: w_mem_wdata = flags_to_word(r_saved_flags);
            ST_VEC_HI:     w_mem_addr  = VEC_ADDR;
            ST_VEC_LO:     w_mem_addr  = VEC_ADDR + 32'd1;
            default:       w_mem_addr  = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_mode        <= MODE_INT;
            r_cnt         <= 4'd0;
            r_ret_pc      <= 32'd0;
            r_saved_flags <= '0;
            r_tgt         <= 32'd0;
            r_stall       <= 1'b0;
            r_flush       <= 1'b0;
            r_busy        <= 1'b0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_sp_op       <= SP_NONE;
            r_mem_addr    <= 32'd0;
            r_mem_wdata   <= 16'd0;
            r_pc_load     <= 1'b0;
            r_pc_load_val <= 32'd0;
            r_clr_int     <= 1'b0;
            r_set_int     <= 1'b0;
            r_int_ack     <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_mode  <= w_next_mode;
            r_cnt   <= w_next_cnt;
            r_tgt   <= w_next_tgt;
            if (w_start && (w_next_mode == MODE_INT)) begin
                r_ret_pc <= next_pc;
            end
            // Flags are sampled on the last drain cycle, once older
            // instructions have retired and updated the CCR.
            if (w_clear_pending) begin
                r_saved_flags <= flags_in;
            end
            r_busy        <= (w_next_state != ST_IDLE);
            r_stall       <= (w_next_state != ST_IDLE);
            r_flush       <= (w_next_state == ST_DRAIN) && (w_next_cnt == 4'd0);
            r_clr_int     <= w_start && (w_next_mode == MODE_INT);
            r_mem_req     <= is_mem_state(w_next_state);
            r_mem_we      <= is_push_state(w_next_state);
            r_sp_op       <= w_sp_op;
            r_mem_addr    <= w_mem_addr;
            r_mem_wdata   <= w_mem_wdata;
            r_pc_load     <= (w_next_state == ST_RESUME);
            r_pc_load_val <= (w_next_state == ST_RESUME) ? w_next_tgt : 32'd0;
            r_int_ack     <= (w_next_state == ST_RESUME) && (r_mode == MODE_INT);
            r_set_int     <= (w_next_state == ST_RESUME) && (r_mode == MODE_RTI);
        end
    end

    // Flag restore must land in the same cycle the popped word is accepted,
    // so it is taken straight from the memory response.
    assign flags_load  = (r_state == ST_POP_FLAGS) && mem_ready;
    assign flags_val   = flags_load ? mem_rdata[FLAGS_W-1:0] : '0;

    assign stall       = r_stall;
    assign flush       = r_flush;
    assign busy        = r_busy;
    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign sp_op       = r_sp_op;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign pc_load     = r_pc_load;
    assign pc_load_val = r_pc_load_val;
    assign clr_int     = r_clr_int;
    assign set_int     = r_set_int;
    assign int_ack     = r_int_ack;

endmodule
`default_nettype wire
